// File: rtl/regfile_wb_scheduler_if.sv
// Signal bundle between the pipeline/long-latency unit side and the register file write-port scheduler.
// The master drives WB, long-unit and ID fields; the slave (scheduler) returns grant, stall and the write port.
interface regfile_wb_scheduler_if;
   logic        wb_reg_write;
   logic [4:0]  wb_rt_rd;
   logic [31:0] wb_write_data;
   logic        lu_valid;
   logic [4:0]  lu_dest;
   logic [31:0] lu_data;
   logic        lu_ready;
   logic        iss_valid;
   logic [4:0]  iss_dest;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_stall;
   logic        rf_reg_write;
   logic [4:0]  rf_rt_rd;
   logic [31:0] rf_write_data;

   modport master (
      output wb_reg_write, wb_rt_rd, wb_write_data,
      output lu_valid, lu_dest, lu_data,
      output iss_valid, iss_dest, id_rs, id_rt,
      input  lu_ready, id_stall,
      input  rf_reg_write, rf_rt_rd, rf_write_data
   );

   modport slave (
      input  wb_reg_write, wb_rt_rd, wb_write_data,
      input  lu_valid, lu_dest, lu_data,
      input  iss_valid, iss_dest, id_rs, id_rt,
      output lu_ready, id_stall,
      output rf_reg_write, rf_rt_rd, rf_write_data
   );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Write-port scheduler and pending scoreboard for the MIPS32 register file (WB has priority over the long unit).
// Define REGFILE_STARVE_GUARD_EN to compile in the starvation guard that forces ID bubbles after STARVE_LIMIT denials.
module regfile_wb_scheduler #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic                    clock,
   input logic                    reset,
   regfile_wb_scheduler_if.slave  bus
);

`ifdef REGFILE_STARVE_GUARD_EN
   typedef enum logic [1:0] {IDLE, WAIT, STARVE} state_t;
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   logic [3:0] cnt;
   logic [3:0] cnt_next;
   logic [3:0] cnt_inc;
`else
   typedef enum logic [1:0] {IDLE, WAIT} state_t;
`endif

   state_t      state;
   state_t      state_next;
   logic        wb_active;
   logic        grant;
   logic        denied;
   logic        starve_stall;
   logic        hazard;
   logic        issue_accept;
   logic [31:0] pending;
   logic [31:0] pending_next;
   logic [31:0] set_mask;
   logic [31:0] clr_mask;

   assign wb_active = bus.wb_reg_write & (bus.wb_rt_rd != 5'd0);
   assign grant     = bus.lu_valid & ~wb_active;
   assign denied    = bus.lu_valid & wb_active;

   assign bus.lu_ready = grant;

   always_comb begin
      bus.rf_reg_write  = 1'b0;
      bus.rf_rt_rd      = 5'd0;
      bus.rf_write_data = 32'd0;
      if (wb_active) begin
         bus.rf_reg_write  = 1'b1;
         bus.rf_rt_rd      = bus.wb_rt_rd;
         bus.rf_write_data = bus.wb_write_data;
      end else if (bus.lu_valid) begin
         bus.rf_reg_write  = (bus.lu_dest != 5'd0);
         bus.rf_rt_rd      = bus.lu_dest;
         bus.rf_write_data = bus.lu_data;
      end
   end

   // Hazards use start-of-cycle pending bits, so a grant only releases readers on the next cycle.
   always_comb begin
      hazard = 1'b0;
      if ((bus.id_rs != 5'd0) && pending[bus.id_rs])
         hazard = 1'b1;
      if ((bus.id_rt != 5'd0) && pending[bus.id_rt])
         hazard = 1'b1;
      if (bus.iss_valid && (bus.iss_dest != 5'd0) && pending[bus.iss_dest])
         hazard = 1'b1;
   end

   assign bus.id_stall  = hazard | starve_stall;
   assign issue_accept  = bus.iss_valid & ~bus.id_stall & (bus.iss_dest != 5'd0);

   always_comb begin
      set_mask = 32'd0;
      clr_mask = 32'd0;
      if (issue_accept)
         set_mask[bus.iss_dest] = 1'b1;
      if (grant)
         clr_mask[bus.lu_dest] = 1'b1;
      pending_next = ((pending & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
   end

   always_ff @(posedge clock) begin
      if (reset)
         pending <= 32'd0;
      else
         pending <= pending_next;
   end

`ifdef REGFILE_STARVE_GUARD_EN
   assign cnt_inc = cnt + 4'd1;
`endif

   // A long-unit result that disappears without a grant (abandoned op) also returns the FSM to IDLE.
   always_comb begin
      state_next   = state;
      starve_stall = 1'b0;
`ifdef REGFILE_STARVE_GUARD_EN
      cnt_next     = cnt;
`endif
      case (state)
         IDLE: begin
            if (denied) begin
`ifdef REGFILE_STARVE_GUARD_EN
               cnt_next   = 4'd1;
               state_next = (LIMIT <= 4'd1) ? STARVE : WAIT;
`else
               state_next = WAIT;
`endif
            end
         end
         WAIT: begin
            if (grant || !bus.lu_valid) begin
               state_next = IDLE;
`ifdef REGFILE_STARVE_GUARD_EN
               cnt_next   = 4'd0;
            end else begin
               cnt_next = cnt_inc;
               if (cnt_inc >= LIMIT)
                  state_next = STARVE;
`endif
            end
         end
`ifdef REGFILE_STARVE_GUARD_EN
         STARVE: begin
            starve_stall = 1'b1;
            if (grant || !bus.lu_valid) begin
               state_next = IDLE;
               cnt_next   = 4'd0;
            end
         end
`endif
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
`ifdef REGFILE_STARVE_GUARD_EN
         cnt   <= 4'd0;
`endif
      end else begin
         state <= state_next;
`ifdef REGFILE_STARVE_GUARD_EN
         cnt   <= cnt_next;
`endif
      end
   end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: table-driven port-mux vectors plus scoreboard, starvation and reset sequences.
module tb_regfile_wb_scheduler;

`ifdef REGFILE_STARVE_GUARD_EN
   localparam logic GUARD = 1'b1;
`else
   localparam logic GUARD = 1'b0;
`endif

   typedef struct {
      logic        wb_we;
      logic [4:0]  wb_rd;
      logic [31:0] wb_data;
      logic        lu_v;
      logic [4:0]  lu_d;
      logic [31:0] lu_dat;
      logic        exp_ready;
      logic        exp_we;
      logic [4:0]  exp_rd;
      logic [31:0] exp_data;
      logic        exp_stall;
   } vec_t;

   logic clock;
   logic reset;
   int   checks;
   int   passes;
   vec_t vecs[10];

   regfile_wb_scheduler_if bus();

   regfile_wb_scheduler #(.STARVE_LIMIT(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic applyStimulus(input logic wb_we, input logic [4:0] wb_rd, input logic [31:0] wb_data,
                                input logic lu_v, input logic [4:0] lu_d, input logic [31:0] lu_dat,
                                input logic iss_v, input logic [4:0] iss_d,
                                input logic [4:0] rs, input logic [4:0] rt);
      bus.wb_reg_write  = wb_we;
      bus.wb_rt_rd      = wb_rd;
      bus.wb_write_data = wb_data;
      bus.lu_valid      = lu_v;
      bus.lu_dest       = lu_d;
      bus.lu_data       = lu_dat;
      bus.iss_valid     = iss_v;
      bus.iss_dest      = iss_d;
      bus.id_rs         = rs;
      bus.id_rt         = rt;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      else
         passes++;
   endtask

   task automatic resetDut();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      checks = 0;
      passes = 0;
      reset  = 1'b0;

      vecs[0] = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 5'd0,  32'h0,          1'b0};
      vecs[1] = '{1'b0, 5'd0,  32'h0,          1'b1, 5'd5,  32'hDEAD_BEEF,  1'b1, 1'b1, 5'd5,  32'hDEAD_BEEF,  1'b0};
      vecs[2] = '{1'b1, 5'd3,  32'h1111_1111,  1'b1, 5'd7,  32'h0000_7777,  1'b0, 1'b1, 5'd3,  32'h1111_1111,  1'b0};
      vecs[3] = '{1'b0, 5'd0,  32'h0,          1'b1, 5'd7,  32'h0000_7777,  1'b1, 1'b1, 5'd7,  32'h0000_7777,  1'b0};
      vecs[4] = '{1'b1, 5'd0,  32'h1234_5678,  1'b1, 5'd12, 32'h0000_ABCD,  1'b1, 1'b1, 5'd12, 32'h0000_ABCD,  1'b0};
      vecs[5] = '{1'b1, 5'd0,  32'h1234_5678,  1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 5'd0,  32'h0,          1'b0};
      vecs[6] = '{1'b0, 5'd0,  32'h0,          1'b1, 5'd0,  32'h0000_0055,  1'b1, 1'b0, 5'd0,  32'h0000_0055,  1'b0};
      vecs[7] = '{1'b0, 5'd8,  32'h0000_0099,  1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 5'd0,  32'h0,          1'b0};
      vecs[8] = '{1'b1, 5'd31, 32'hFFFF_FFFF,  1'b0, 5'd0,  32'h0,          1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF,  1'b0};
      vecs[9] = '{1'b0, 5'd4,  32'h0000_0044,  1'b1, 5'd31, 32'h0000_CAFE,  1'b1, 1'b1, 5'd31, 32'h0000_CAFE,  1'b0};

      resetDut();
      checkOutput("reset_lu_ready", {31'd0, bus.lu_ready}, 32'd0);
      checkOutput("reset_id_stall", {31'd0, bus.id_stall}, 32'd0);
      checkOutput("reset_rf_we", {31'd0, bus.rf_reg_write}, 32'd0);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].wb_we, vecs[i].wb_rd, vecs[i].wb_data,
                       vecs[i].lu_v, vecs[i].lu_d, vecs[i].lu_dat, 0, 0, 0, 0);
         checkOutput($sformatf("vec%0d_lu_ready", i), {31'd0, bus.lu_ready}, {31'd0, vecs[i].exp_ready});
         checkOutput($sformatf("vec%0d_rf_we", i), {31'd0, bus.rf_reg_write}, {31'd0, vecs[i].exp_we});
         checkOutput($sformatf("vec%0d_rf_rd", i), {27'd0, bus.rf_rt_rd}, {27'd0, vecs[i].exp_rd});
         checkOutput($sformatf("vec%0d_rf_data", i), bus.rf_write_data, vecs[i].exp_data);
         checkOutput($sformatf("vec%0d_id_stall", i), {31'd0, bus.id_stall}, {31'd0, vecs[i].exp_stall});
         tick();
      end

      // Scoreboard: RAW on rs/rt, WAW reissue, blocked issue, release one cycle after grant.
      resetDut();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
      checkOutput("issue_r9_no_stall", {31'd0, bus.id_stall}, 32'd0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
      checkOutput("raw_rs_r9", {31'd0, bus.id_stall}, 32'd1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
      checkOutput("raw_rs_r9_held", {31'd0, bus.id_stall}, 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
      checkOutput("raw_rt_r9", {31'd0, bus.id_stall}, 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("rs_r0_no_stall", {31'd0, bus.id_stall}, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
      checkOutput("waw_r9_stall", {31'd0, bus.id_stall}, 32'd1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 10, 9, 0);
      checkOutput("issue_blocked_by_raw", {31'd0, bus.id_stall}, 32'd1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 10, 0);
      checkOutput("r10_not_pending", {31'd0, bus.id_stall}, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
      checkOutput("r9_still_pending", {31'd0, bus.id_stall}, 32'd1);
      applyStimulus(0, 0, 0, 1, 9, 32'h0000_9999, 0, 0, 9, 0);
      checkOutput("grant_r9_ready", {31'd0, bus.lu_ready}, 32'd1);
      checkOutput("grant_r9_rd", {27'd0, bus.rf_rt_rd}, 32'd9);
      checkOutput("grant_r9_data", bus.rf_write_data, 32'h0000_9999);
      checkOutput("grant_cycle_still_stall", {31'd0, bus.id_stall}, 32'd1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
      checkOutput("released_after_grant", {31'd0, bus.id_stall}, 32'd0);

      // Starvation: four denied cycles, then bubbles (guard build only) until WB goes idle.
      resetDut();
      for (int c = 1; c <= 4; c++) begin
         applyStimulus(1, 3, 32'h0000_0033, 1, 6, 32'h0000_0066, 0, 0, 0, 0);
         checkOutput($sformatf("starve_denied%0d_ready", c), {31'd0, bus.lu_ready}, 32'd0);
         checkOutput($sformatf("starve_denied%0d_stall", c), {31'd0, bus.id_stall}, 32'd0);
         tick();
      end
      applyStimulus(1, 3, 32'h0000_0033, 1, 6, 32'h0000_0066, 0, 0, 0, 0);
      checkOutput("starve_stall_rises", {31'd0, bus.id_stall}, {31'd0, GUARD});
      tick();
      applyStimulus(1, 3, 32'h0000_0033, 1, 6, 32'h0000_0066, 0, 0, 0, 0);
      checkOutput("starve_stall_holds", {31'd0, bus.id_stall}, {31'd0, GUARD});
      tick();
      applyStimulus(0, 0, 0, 1, 6, 32'h0000_0066, 0, 0, 0, 0);
      checkOutput("starve_grant_ready", {31'd0, bus.lu_ready}, 32'd1);
      checkOutput("starve_grant_rd", {27'd0, bus.rf_rt_rd}, 32'd6);
      checkOutput("starve_grant_stall", {31'd0, bus.id_stall}, {31'd0, GUARD});
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("starve_back_to_idle", {31'd0, bus.id_stall}, 32'd0);

      // Reset with r4 pending and the arbiter starved.
      resetDut();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
      tick();
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1, 3, 32'h0000_0033, 1, 2, 32'h0000_0022, 0, 0, 4, 0);
         tick();
      end
      checkOutput("pre_reset_stall", {31'd0, bus.id_stall}, 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
      checkOutput("post_reset_r4_clear", {31'd0, bus.id_stall}, 32'd0);
      checkOutput("post_reset_rf_we", {31'd0, bus.rf_reg_write}, 32'd0);
      checkOutput("post_reset_lu_ready", {31'd0, bus.lu_ready}, 32'd0);
      applyStimulus(1, 3, 32'h0000_0033, 1, 2, 32'h0000_0022, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("post_reset_fsm_idle", {31'd0, bus.id_stall}, 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
